dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder on the Rd/Wr/Done/Stall/CacheHit handshake.
// A single-line tracker decides hit vs. miss latency; storage survives reset.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int ADDR_BITS    = 15,
  parameter int HIT_LATENCY  = 1,
  parameter int MISS_LATENCY = 4,
  parameter int LINE_BITS    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int TAG_W = 16 - LINE_BITS;
  localparam logic [3:0] HIT_CNT  = 4'(HIT_LATENCY - 1);
  localparam logic [3:0] MISS_CNT = 4'(MISS_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               hit_q, hit_d;
  logic               err_q, err_d;
  logic               line_valid_q, line_valid_d;
  logic [TAG_W-1:0]   last_line_q, last_line_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               req_hit;
  logic               enter_done;
  logic               mem_we;
  logic [ADDR_BITS-1:0] mem_idx;

  logic [15:0] mem_q [0:(1<<ADDR_BITS)-1];

  // createdump only drives a simulation dump in the reference model; no hardware effect.
  logic unused_createdump;
  assign unused_createdump = createdump;

  assign req_hit = line_valid_q && (Addr[15:LINE_BITS] == last_line_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    hit_d        = hit_q;
    err_d        = err_q;
    line_valid_d = line_valid_q;
    last_line_d  = last_line_q;
    rdata_d      = rdata_q;
    enter_done   = 1'b0;
    mem_we       = 1'b0;
    Done         = 1'b0;
    Stall        = 1'b0;
    CacheHit     = 1'b0;
    err          = 1'b0;
    DataOut      = '0;

    case (state_q)
      S_IDLE: begin
        Stall = Rd | Wr;
        if (Rd | Wr) begin
          addr_d  = Addr;
          wdata_d = DataIn;
          wr_d    = Wr;
          if ((Rd & Wr) | Addr[0]) begin
            err_d   = 1'b1;
            hit_d   = 1'b0;
            cnt_d   = '0;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            err_d = 1'b0;
            hit_d = req_hit;
            cnt_d = req_hit ? HIT_CNT : MISS_CNT;
            if (cnt_d == '0) begin
              state_d    = S_DONE;
              enter_done = 1'b1;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
      end
      S_BUSY: begin
        Stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        Done     = 1'b1;
        CacheHit = hit_q & ~err_q;
        err      = err_q;
        DataOut  = rdata_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // addr_d/wdata_d/wr_d hold the live request on a single-cycle hit and the latched one otherwise.
    mem_idx = addr_d[ADDR_BITS:1];
    if (enter_done) begin
      if (wr_d) begin
        mem_we  = 1'b1;
        rdata_d = '0;
      end else begin
        rdata_d = mem_q[mem_idx];
      end
      last_line_d  = addr_d[15:LINE_BITS];
      line_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      line_valid_q <= 1'b0;
      last_line_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      line_valid_q <= line_valid_d;
      last_line_q  <= last_line_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_idx] <= wdata_d;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, hit tracking, errors, reset abort, back-to-back.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, createdump;
  logic        Done, Stall, CacheHit, err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  dmem_responder #(
    .ADDR_BITS(15), .HIT_LATENCY(1), .MISS_LATENCY(4), .LINE_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request for a single cycle, then measure latency and check the completion cycle.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d, input int lat,
                        input logic hit, input logic er, input logic [15:0] data);
    int seen;
    seen = 0;
    @(posedge clk); #1;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(negedge clk);
    check({tag, ".stall_req"}, 16'(Stall), 16'd1);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (Done) seen = c;
    end
    check({tag, ".lat"}, 16'(seen), 16'(lat));
    if (seen != 0) begin
      check({tag, ".hit"},   16'(CacheHit), 16'(hit));
      check({tag, ".err"},   16'(err),      16'(er));
      check({tag, ".data"},  DataOut,       data);
      check({tag, ".stall"}, 16'(Stall),    16'd0);
    end
  endtask

  initial begin
    int abort_done;
    int d1, d2;
    Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; createdump = 1'b0; rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst.done",  16'(Done),     16'd0);
    check("rst.stall", 16'(Stall),    16'd0);
    check("rst.hit",   16'(CacheHit), 16'd0);
    check("rst.err",   16'(err),      16'd0);
    check("rst.data",  DataOut,       16'h0000);
    rst = 1'b0;

    // Preload; tracker ends on line 0x0010 so the reset below must invalidate it.
    access("pre40", 1'b0, 1'b1, 16'h0040, 16'h4040, 4, 1'b0, 1'b0, 16'h0000);
    access("pre42", 1'b0, 1'b1, 16'h0042, 16'h4242, 1, 1'b1, 1'b0, 16'h0000);
    access("pre18", 1'b0, 1'b1, 16'h0018, 16'h1818, 4, 1'b0, 1'b0, 16'h0000);
    access("pre20", 1'b0, 1'b1, 16'h0020, 16'h2020, 4, 1'b0, 1'b0, 16'h0000);
    access("pre14", 1'b0, 1'b1, 16'h0014, 16'h1414, 4, 1'b0, 1'b0, 16'h0000);
    access("pre10", 1'b0, 1'b1, 16'h0010, 16'hA5A5, 1, 1'b1, 1'b0, 16'h0000);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    access("rd10", 1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 1'b0, 16'hA5A5);
    createdump = 1'b1;
    access("wr12", 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1, 1'b1, 1'b0, 16'h0000);
    createdump = 1'b0;
    access("rd12", 1'b1, 1'b0, 16'h0012, 16'h0000, 1, 1'b1, 1'b0, 16'hBEEF);
    access("rd20", 1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, 1'b0, 16'h2020);
    access("rd18", 1'b1, 1'b0, 16'h0018, 16'h0000, 4, 1'b0, 1'b0, 16'h1818);
    access("err13", 1'b1, 1'b0, 16'h0013, 16'h0000, 1, 1'b0, 1'b1, 16'h0000);
    access("errRW", 1'b1, 1'b1, 16'h0014, 16'hDEAD, 1, 1'b0, 1'b1, 16'h0000);
    access("rd14", 1'b1, 1'b0, 16'h0014, 16'h0000, 4, 1'b0, 1'b0, 16'h1414);

    // Write aborted by reset in the second BUSY cycle.
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h1234;
    @(posedge clk); #1 Wr = 1'b0;
    abort_done = 0;
    @(negedge clk);
    if (Done) abort_done++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (Done) abort_done++;
    end
    check("abort.done", 16'(abort_done), 16'd0);

    // Request held across DONE: miss on 0x0040 then an immediate hit on 0x0042.
    d1 = -1; d2 = -1;
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0040;
    for (int c = 0; c < 30 && d2 < 0; c++) begin
      @(negedge clk);
      if (Done) begin
        if (d1 < 0) begin
          d1 = c;
          check("held1.data", DataOut, 16'h4040);
          check("held1.hit",  16'(CacheHit), 16'd0);
          Addr = 16'h0042;
        end else begin
          d2 = c;
          check("held2.data", DataOut, 16'h4242);
          check("held2.hit",  16'(CacheHit), 16'd1);
          Rd = 1'b0;
        end
      end
    end
    check("held1.lat", 16'(d1), 16'd4);
    check("held.gap",  16'(d2 - d1), 16'd2);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
